cv32e40x_rr_arbiter: RTL and testbench
======================================

CV32E40X_RR_ARBITER -- requirements
Module: cv32e40x_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port req_i, input, NUM_REQ bits, one request per requester, held high for the whole transaction.
REQ-005 The block SHALL have port last_i, input, 1 bit, marking the final beat of the granted transaction.
REQ-006 The block SHALL have port ready_i, input, 1 bit, meaning the shared resource accepts a beat this cycle.
REQ-007 The block SHALL have port gnt_o, output, NUM_REQ bits, the one-hot grant vector.
REQ-008 The block SHALL have port gnt_idx_o, output, $clog2(NUM_REQ) bits, the binary index of the current or most recent grant.
REQ-009 The block SHALL have port valid_o, output, 1 bit, meaning the granted requester presents a beat to the resource.
REQ-010 The block SHALL have port conflict_cnt_o, output, 16 bits, the contention counter (see Configuration).

Function
REQ-011 The block SHALL implement two states: IDLE and BUSY.
REQ-012 In IDLE with req_i nonzero, the block SHALL pick the lowest set index at or above priority pointer ptr; if no such bit is set, it SHALL pick the lowest set index overall.
REQ-013 The winner SHALL be registered into gnt_idx_o and the state SHALL move to BUSY on the same edge; request-to-grant latency is exactly 1 cycle.
REQ-014 In IDLE, gnt_o and valid_o SHALL be 0, and gnt_idx_o SHALL hold its last value.
REQ-015 In BUSY, gnt_o SHALL be one-hot at gnt_idx_o, and valid_o SHALL equal req_i[gnt_idx_o].
REQ-016 A beat SHALL be accepted when valid_o and ready_i are both 1; an accepted beat with last_i=1 completes the transaction.
REQ-017 On completion, the state SHALL go to IDLE and ptr SHALL become gnt_idx_o+1, wrapping from NUM_REQ-1 to 0, including for non-power-of-2 NUM_REQ.
REQ-018 In BUSY, a 0 on req_i[gnt_idx_o] SHALL abort the transaction: the state goes to IDLE and ptr advances as on completion.
REQ-019 The block SHALL insert exactly one IDLE bubble cycle between transactions; grants are never back-to-back.
REQ-020 Beats with last_i=0, and cycles with ready_i=0, SHALL keep the state BUSY with the grant unchanged.
REQ-021 Requests from non-granted requesters SHALL NOT affect gnt_o while in BUSY.
REQ-022 ready_i and last_i SHALL be ignored in IDLE.
REQ-023 gnt_o SHALL never have more than one bit set.

Reset
REQ-024 When rst=1 at a clock edge, the state SHALL become IDLE, with ptr=0, gnt_idx_o=0, gnt_o=0, valid_o=0 and conflict_cnt_o=0.
REQ-025 Reset asserted during BUSY SHALL drop the grant; no grant SHALL appear in the cycle following the reset edge.

Configuration
REQ-026 With macro CV32E40X_RR_ARB_PERF_EN defined, conflict_cnt_o SHALL increment once per cycle in which two or more req_i bits are set; it saturates at 0xFFFF and clears only on reset.
REQ-027 Without CV32E40X_RR_ARB_PERF_EN, the counter logic SHALL be absent and conflict_cnt_o SHALL be tied to 0.

Verification
REQ-028 Reset/idle: with NUM_REQ=4, hold rst=1 for 2 cycles with req_i=4'b1111 -> gnt_o=0 and valid_o=0 throughout.
REQ-029 Rotation: NUM_REQ=4, req_i=4'b1111 held, ready_i=1, last_i=1 -> grants follow indices 0,1,2,3,0, each separated by one idle cycle.
REQ-030 Multi-beat stall: grant to index 2, ready_i low for 3 cycles, then 3 beats with last on the third -> gnt_o=4'b0100 for all 6 cycles, then IDLE with ptr=3.
REQ-031 Abort and wrap: NUM_REQ=3, grant index 2, drop req_i[2] mid-transfer -> IDLE next cycle; the next grant goes to index 0 when req_i=3'b011.
REQ-032 Reset mid-BUSY: assert rst while index 1 is granted -> gnt_o=0 the next cycle, and the first grant after reset goes to index 0 when req_i=4'b0011.
REQ-033 Counter: with the macro defined, 70000 cycles with req_i=4'b0011 -> conflict_cnt_o=0xFFFF; with the macro undefined -> conflict_cnt_o=0 always.

Source files
------------

// File: rtl/cv32e40x_rr_arbiter.sv
// Round-robin arbiter that holds each grant for a multi-beat transaction and inserts one idle cycle between grants.
// Optional contention counter is built only when CV32E40X_RR_ARB_PERF_EN is defined.
module cv32e40x_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       last_i,
  input  logic                       ready_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       valid_o,
  output logic [15:0]                conflict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic [IDX_W-1:0]   winner;
  logic               hi_found;
  logic               lo_found;
  logic [IDX_W-1:0]   ptr_next;
  logic               cur_req;

  // Lowest requester at or above the pointer, falling back to the lowest overall.
  always_comb begin
    winner   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hi_found && req_i[i] && (i >= 32'(ptr_q))) begin
        winner   = IDX_W'(i);
        hi_found = 1'b1;
      end
    end
    if (!hi_found) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!lo_found && req_i[i]) begin
          winner   = IDX_W'(i);
          lo_found = 1'b1;
        end
      end
    end
  end

  // Explicit wrap keeps non-power-of-2 requester counts in range.
  assign ptr_next = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
  assign cur_req  = req_i[gnt_idx_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_d     = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = BUSY;
          gnt_idx_d = winner;
          gnt_d     = NUM_REQ'(1) << winner;
        end
      end
      BUSY: begin
        // Dropped request aborts; an accepted last beat completes. Both rotate the pointer.
        if (!cur_req || (ready_i && last_i)) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx_q;
  // valid follows the live request so an abort is visible in the same cycle.
  assign valid_o   = (state_q == BUSY) && cur_req;

`ifdef CV32E40X_RR_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             multi_req;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi_req = |(req_i & (req_i - NUM_REQ'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (multi_req && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40x_rr_arbiter.sv
// Directed vector bench for cv32e40x_rr_arbiter (4-requester and 3-requester instances).
module tb_cv32e40x_rr_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, last4, ready4;
  logic [3:0]  req4, gnt4;
  logic [1:0]  idx4;
  logic        valid4;
  logic [15:0] cnt4;

  logic        rst3, last3, ready3;
  logic [2:0]  req3, gnt3;
  logic [1:0]  idx3;
  logic        valid3;
  logic [15:0] cnt3;

  cv32e40x_rr_arbiter #(.NUM_REQ(4)) u_dut4 (
    .clk(clk), .rst(rst4), .req_i(req4), .last_i(last4), .ready_i(ready4),
    .gnt_o(gnt4), .gnt_idx_o(idx4), .valid_o(valid4), .conflict_cnt_o(cnt4)
  );

  cv32e40x_rr_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_i(req3), .last_i(last3), .ready_i(ready3),
    .gnt_o(gnt3), .gnt_idx_o(idx3), .valid_o(valid3), .conflict_cnt_o(cnt3)
  );

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       last;
    logic [3:0] exp_gnt;
    logic [1:0] exp_idx;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[29];

`ifdef CV32E40X_RR_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic logic [15:0] exp_cnt(input int unsigned n);
    if (!PERF) return 16'h0000;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  initial begin
    // {rst, req, ready, last, exp_gnt, exp_idx, exp_valid}: expectations are after the edge
    vecs[0]  = '{1, 4'b1111, 1, 1, 4'b0000, 2'd0, 0};
    vecs[1]  = '{1, 4'b1111, 1, 1, 4'b0000, 2'd0, 0};
    vecs[2]  = '{0, 4'b1111, 1, 1, 4'b0001, 2'd0, 1};
    vecs[3]  = '{0, 4'b1111, 1, 1, 4'b0000, 2'd0, 0};
    vecs[4]  = '{0, 4'b1111, 1, 1, 4'b0010, 2'd1, 1};
    vecs[5]  = '{0, 4'b1111, 1, 1, 4'b0000, 2'd1, 0};
    vecs[6]  = '{0, 4'b1111, 1, 1, 4'b0100, 2'd2, 1};
    vecs[7]  = '{0, 4'b1111, 1, 1, 4'b0000, 2'd2, 0};
    vecs[8]  = '{0, 4'b1111, 1, 1, 4'b1000, 2'd3, 1};
    vecs[9]  = '{0, 4'b1111, 1, 1, 4'b0000, 2'd3, 0};
    vecs[10] = '{0, 4'b1111, 1, 1, 4'b0001, 2'd0, 1};
    vecs[11] = '{0, 4'b1111, 1, 1, 4'b0000, 2'd0, 0};
    // ptr=1: grant 2, three stalls, then three beats with last on the third
    vecs[12] = '{0, 4'b0100, 0, 0, 4'b0100, 2'd2, 1};
    vecs[13] = '{0, 4'b1111, 0, 1, 4'b0100, 2'd2, 1};
    vecs[14] = '{0, 4'b1111, 0, 1, 4'b0100, 2'd2, 1};
    vecs[15] = '{0, 4'b1111, 0, 1, 4'b0100, 2'd2, 1};
    vecs[16] = '{0, 4'b1111, 1, 0, 4'b0100, 2'd2, 1};
    vecs[17] = '{0, 4'b1111, 1, 0, 4'b0100, 2'd2, 1};
    vecs[18] = '{0, 4'b1111, 1, 1, 4'b0000, 2'd2, 0};
    // ptr=3 now; ready/last high in IDLE must not matter
    vecs[19] = '{0, 4'b1111, 1, 1, 4'b1000, 2'd3, 1};
    vecs[20] = '{0, 4'b1111, 1, 1, 4'b0000, 2'd3, 0};
    // ptr=0: grant 1, reset mid-transfer, then first grant goes to 0
    vecs[21] = '{0, 4'b0010, 0, 0, 4'b0010, 2'd1, 1};
    vecs[22] = '{1, 4'b0011, 0, 0, 4'b0000, 2'd0, 0};
    vecs[23] = '{0, 4'b0011, 0, 0, 4'b0001, 2'd0, 1};
    vecs[24] = '{0, 4'b0011, 0, 0, 4'b0001, 2'd0, 1};
    // drop req[0] -> abort, ptr=1
    vecs[25] = '{0, 4'b0010, 1, 0, 4'b0000, 2'd0, 0};
    vecs[26] = '{0, 4'b0011, 0, 0, 4'b0010, 2'd1, 1};
    vecs[27] = '{0, 4'b0011, 1, 1, 4'b0000, 2'd1, 0};
    vecs[28] = '{0, 4'b0000, 1, 1, 4'b0000, 2'd1, 0};

    rst3 = 1; req3 = '0; ready3 = 0; last3 = 0;
    rst4 = 1; req4 = '0; ready4 = 0; last4 = 0;
    @(negedge clk);

    for (int i = 0; i < 29; i++) begin
      rst4 = vecs[i].rst; req4 = vecs[i].req; ready4 = vecs[i].ready; last4 = vecs[i].last;
      @(posedge clk); #1;
      chk($sformatf("v%0d gnt", i),   32'(gnt4),   32'(vecs[i].exp_gnt));
      chk($sformatf("v%0d idx", i),   32'(idx4),   32'(vecs[i].exp_idx));
      chk($sformatf("v%0d valid", i), 32'(valid4), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d onehot", i), 32'($countones(gnt4) <= 1), 32'd1);
    end

    // 3 requesters: grant 2, abort, pointer wraps to 0
    rst3 = 1; @(posedge clk); #1;
    chk("n3 reset gnt", 32'(gnt3), 32'd0);
    rst3 = 0; req3 = 3'b100; ready3 = 0;
    @(posedge clk); #1;
    chk("n3 grant2 gnt", 32'(gnt3), 32'b100);
    chk("n3 grant2 idx", 32'(idx3), 32'd2);
    ready3 = 1; last3 = 0;
    @(posedge clk); #1;
    chk("n3 beat gnt", 32'(gnt3), 32'b100);
    req3 = 3'b000;
    #1 chk("n3 abort valid", 32'(valid3), 32'd0);
    @(posedge clk); #1;
    chk("n3 abort gnt", 32'(gnt3), 32'd0);
    chk("n3 abort idx", 32'(idx3), 32'd2);
    req3 = 3'b011;
    @(posedge clk); #1;
    chk("n3 wrap gnt", 32'(gnt3), 32'b001);
    chk("n3 wrap idx", 32'(idx3), 32'd0);
    last3 = 1;
    @(posedge clk); #1;
    chk("n3 done gnt", 32'(gnt3), 32'd0);
    req3 = 3'b101; last3 = 0;
    @(posedge clk); #1;
    chk("n3 ptr1 idx", 32'(idx3), 32'd2);
    chk("n3 cnt", 32'(cnt3), PERF ? 32'd3 : 32'd0);

    // contention counter on the 4-requester instance
    rst4 = 1; req4 = 4'b0011; ready4 = 0; last4 = 0;
    @(posedge clk); #1;
    chk("cnt reset", 32'(cnt4), 32'd0);
    rst4 = 0;
    @(posedge clk); #1;
    chk("cnt 1", 32'(cnt4), 32'(exp_cnt(1)));
    repeat (65533) @(posedge clk);
    #1 chk("cnt 65534", 32'(cnt4), 32'(exp_cnt(65534)));
    @(posedge clk); #1;
    chk("cnt 65535", 32'(cnt4), 32'(exp_cnt(65535)));
    repeat (4465) @(posedge clk);
    #1 chk("cnt 70000 sat", 32'(cnt4), 32'(exp_cnt(70000)));
    req4 = 4'b0100;
    @(posedge clk); #1;
    chk("cnt single req", 32'(cnt4), 32'(exp_cnt(70000)));
    rst4 = 1;
    @(posedge clk); #1;
    chk("cnt clear", 32'(cnt4), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
